// File: rtl/led_seq_pkg.sv
// Shared mode codes and FSM state encodings for the LED sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_PATTERN = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam int REPEAT_W = 4;

endpackage

// File: rtl/led_tick.sv
// Free-running step-rate divider: one-cycle strobe every FREQ/TICK_HZ clocks.
module led_tick #(
  parameter int FREQ    = 25000000,
  parameter int TICK_HZ = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int DIV   = FREQ / TICK_HZ;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick_o = (cnt == LAST);

endmodule

// File: rtl/led_seq.sv
// LED sequencer: static ON/OFF, blinking, or MSB-first bit patterns with
// an optional finite pass count, driven by a ready/valid command port.
module led_seq #(
  parameter int FREQ    = 25000000,
  parameter int TICK_HZ = 10,
  parameter int PAT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_mode_i,
  input  logic [PAT_W-1:0] cmd_pattern_i,
  input  logic [3:0]       cmd_repeat_i,
  input  logic             abort_i,
  output logic             led_o,
  output logic             busy_o,
  output logic             done_o
);

  import led_seq_pkg::*;

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  state_t               state;
  mode_t                mode_q;
  logic [PAT_W-1:0]     pat_q;
  logic [IDX_W-1:0]     idx_q;
  logic [REPEAT_W-1:0]  pass_q;
  logic                 ready_q;
  logic                 accept;
  logic                 tick;

  // Abort wins over a simultaneous command, so it masks ready directly.
  assign cmd_ready_o = ready_q & ~abort_i;
  assign accept      = cmd_valid_i & cmd_ready_o;

  led_tick #(
    .FREQ    (FREQ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (accept),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_OFF;
      pat_q   <= '0;
      idx_q   <= '0;
      pass_q  <= '0;
      ready_q <= 1'b1;
      led_o   <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        state   <= ST_IDLE;
        led_o   <= 1'b0;
        busy_o  <= 1'b0;
        ready_q <= 1'b1;
      end else if (accept) begin
        mode_q  <= mode_t'(cmd_mode_i);
        pat_q   <= cmd_pattern_i;
        idx_q   <= IDX_MSB;
        pass_q  <= cmd_repeat_i;
        ready_q <= 1'b1;
        case (mode_t'(cmd_mode_i))
          MODE_OFF: begin
            state  <= ST_HOLD;
            led_o  <= 1'b0;
            busy_o <= 1'b0;
          end
          MODE_ON: begin
            state  <= ST_HOLD;
            led_o  <= 1'b1;
            busy_o <= 1'b0;
          end
          MODE_BLINK: begin
            state  <= ST_RUN;
            led_o  <= 1'b1;
            busy_o <= 1'b1;
          end
          default: begin
            state   <= ST_RUN;
            led_o   <= cmd_pattern_i[PAT_W-1];
            busy_o  <= 1'b1;
            ready_q <= (cmd_repeat_i == '0);
          end
        endcase
      end else begin
        case (state)
          ST_RUN: begin
            if (tick) begin
              if (mode_q == MODE_BLINK) begin
                led_o <= ~led_o;
              end else if (idx_q == '0) begin
                // End of a pass; a zero pass count means loop forever.
                if (pass_q == REPEAT_W'(1)) begin
                  state   <= ST_FIN;
                  led_o   <= 1'b0;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
                  ready_q <= 1'b1;
                end else begin
                  if (pass_q != '0) begin
                    pass_q <= pass_q - 1'b1;
                  end
                  idx_q <= IDX_MSB;
                  led_o <= pat_q[PAT_W-1];
                end
              end else begin
                idx_q <= idx_q - 1'b1;
                led_o <= pat_q[idx_q - 1'b1];
              end
            end
          end
          ST_FIN: begin
            state <= ST_IDLE;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_seq.sv
// Randomised and scenario-driven bench for led_seq, checked cycle by cycle
// against a timing model expressed in accept-cycle arithmetic.
module tb_led_seq;

  localparam int FREQ    = 100;
  localparam int TICK_HZ = 10;
  localparam int DIV     = FREQ / TICK_HZ;
  localparam int PAT_W   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_mode = 2'd0;
  logic [PAT_W-1:0] cmd_pattern = '0;
  logic [3:0]       cmd_repeat = 4'd0;
  logic             abort = 1'b0;
  logic             led;
  logic             busy;
  logic             done;

  int vec_cnt = 0;
  int err_cnt = 0;

  led_seq #(.FREQ(FREQ), .TICK_HZ(TICK_HZ), .PAT_W(PAT_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_mode_i    (cmd_mode),
    .cmd_pattern_i (cmd_pattern),
    .cmd_repeat_i  (cmd_repeat),
    .abort_i       (abort),
    .led_o         (led),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  // Reference model: the last accepted command and its accept cycle.
  int         t = 0;
  bit         m_act = 0;
  int         m_mode = 0;
  int         m_n = 0;
  bit [7:0]   m_pat = '0;
  int         m_rep = 0;

  function automatic void model_out(input int tc, output logic e_led,
                                    output logic e_busy, output logic e_done,
                                    output logic e_rdy);
    int k;
    e_led = 0; e_busy = 0; e_done = 0; e_rdy = 1;
    if (m_act) begin
      k = (tc - m_n - 1) / DIV;
      case (m_mode)
        0: e_led = 0;
        1: e_led = 1;
        2: begin e_led = ((k % 2) == 0); e_busy = 1; end
        default: begin
          if (m_rep != 0 && k >= m_rep * PAT_W) begin
            e_done = 1;
          end else begin
            e_led  = m_pat[PAT_W - 1 - (k % PAT_W)];
            e_busy = 1;
            e_rdy  = (m_rep == 0);
          end
        end
      endcase
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, t, got, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, clock, update model.
  task automatic step(input bit r, input bit v, input int md, input bit [7:0] p,
                      input int rp, input bit ab);
    logic e_led, e_busy, e_done, e_rdy;
    rst = r; cmd_valid = v; cmd_mode = md[1:0]; cmd_pattern = p;
    cmd_repeat = rp[3:0]; abort = ab;
    #1;
    model_out(t, e_led, e_busy, e_done, e_rdy);
    e_rdy = e_rdy & ~ab;
    chk("led", {31'd0, led}, {31'd0, e_led});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("ready", {31'd0, cmd_ready}, {31'd0, e_rdy});
    @(posedge clk);
    if (r || ab) begin
      m_act = 0;
    end else if (v && e_rdy) begin
      m_act = 1; m_mode = md; m_n = t; m_pat = p; m_rep = rp;
    end else if (e_done) begin
      m_act = 0;
    end
    t++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_led", {31'd0, led}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 0;

    // Two passes of 1010_0000.
    step(0, 1, 3, 8'b1010_0000, 2, 0);
    idle(170);
    // Blink, then ON preempts 25 cycles later.
    step(0, 1, 2, 8'h00, 0, 0);
    idle(24);
    step(0, 1, 1, 8'h00, 0, 0);
    idle(15);
    // Abort with a command offered at the same time.
    step(0, 1, 3, 8'b1100_1010, 3, 0);
    idle(39);
    step(0, 1, 1, 8'h00, 0, 1);
    idle(10);
    // Endless pattern.
    step(0, 1, 3, 8'b1110_0100, 0, 0);
    idle(300);
    // Command offered in the FIN cycle.
    step(0, 1, 3, 8'hFF, 1, 0);
    idle(80);
    step(0, 1, 2, 8'h00, 0, 0);
    idle(12);
    // Reset in the middle of a blink.
    idle(3);
    step(1, 0, 0, 8'h00, 0, 0);
    idle(4);
    // All-zero pattern keeps its timing and done pulse.
    step(0, 1, 3, 8'h00, 1, 0);
    idle(90);
    // OFF command.
    step(0, 1, 0, 8'hFF, 0, 0);
    idle(5);

    for (int i = 0; i < 4000; i++) begin
      int r;
      bit [7:0] p;
      r = $urandom_range(0, 999);
      p = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      step(r == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 3), p,
           $urandom_range(0, 3), (r > 0 && r < 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
